// File: rtl/ov7670_pkg.sv
// Shared OV7670 definitions: frame-timing FSM states, default 320x240 timing and
// RGB565 frame-memory widths, used by both the capture and streaming paths.
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_e;

    localparam int DEF_H_ACTIVE    = 320;
    localparam int DEF_V_ACTIVE    = 240;
    localparam int DEF_H_BLANK     = 144;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_V_BACK      = 17;
    localparam int DEF_V_FRONT     = 10;

    localparam int ADDR_W = 17;
    localparam int PIX_W  = 16;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter running 0..maxv-1, never narrower than one bit.
    function automatic int cnt_w(input int maxv);
        return (maxv > 1) ? $clog2(maxv) : 1;
    endfunction

endpackage

// File: rtl/ov7670_frame_streamer_if.sv
// Control, frame-memory read port and camera byte stream of the frame streamer.
interface ov7670_frame_streamer_if;
    import ov7670_pkg::*;

    logic              start;
    logic              continuous;
    logic              busy;
    logic              frame_done;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [PIX_W-1:0]  mem_rdata;
    logic              href;
    logic              vsync;
    logic [7:0]        data;

    modport master (
        input  start, continuous, mem_rdata,
        output busy, frame_done, mem_re, mem_raddr, href, vsync, data
    );

    modport slave (
        output start, continuous, mem_rdata,
        input  busy, frame_done, mem_re, mem_raddr, href, vsync, data
    );

endinterface

// File: rtl/ov7670_timing_gen.sv
// Frame/line timing for the streamer: hcnt/lcnt, frame FSM, registered href/vsync/
// frame_done, plus the pixel read strobe issued two cycles ahead of each high byte.
module ov7670_timing_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input  logic pclk,
    input  logic reset,
    input  logic start_i,
    input  logic continuous_i,
    output logic busy_o,
    output logic frame_done_o,
    output logic href_o,
    output logic vsync_o,
    output logic rd_en_o,
    output logic line_start_o
);
    localparam int L  = 2*H_ACTIVE + H_BLANK;
    localparam int HW = cnt_w(L);
    localparam int LW = cnt_w(max2(max2(VSYNC_LINES, V_BACK), max2(V_ACTIVE, V_FRONT)));

    localparam logic [HW-1:0] H_LAST   = HW'(L-1);
    localparam logic [HW-1:0] H_PRE    = HW'(L-2);
    localparam logic [HW-1:0] HREF_END = HW'(2*H_ACTIVE);
    localparam logic [HW-1:0] RD_LAST  = HW'((H_ACTIVE >= 2) ? 2*H_ACTIVE-4 : 0);
    localparam logic [LW-1:0] VS_LAST  = LW'(VSYNC_LINES-1);
    localparam logic [LW-1:0] VB_LAST  = LW'((V_BACK > 0) ? V_BACK-1 : 0);
    localparam logic [LW-1:0] VA_LAST  = LW'(V_ACTIVE-1);
    localparam logic [LW-1:0] VF_LAST  = LW'((V_FRONT > 0) ? V_FRONT-1 : 0);

    state_e          state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [LW-1:0]   lcnt_q, lcnt_d;
    logic            busy_q, frame_done_q, href_q, vsync_q, rd_en_q, line_start_q;

    function automatic logic [LW-1:0] last_line(input state_e s);
        case (s)
            ST_VSYNC:  return VS_LAST;
            ST_VBACK:  return VB_LAST;
            ST_ACTIVE: return VA_LAST;
            default:   return VF_LAST;
        endcase
    endfunction

    // Zero-length VBACK/VFRONT are skipped here, so they are never entered.
    function automatic state_e next_state(input state_e s, input logic cont);
        case (s)
            ST_VSYNC:  return (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
            ST_VBACK:  return ST_ACTIVE;
            ST_ACTIVE: return (V_FRONT > 0) ? ST_VFRONT : (cont ? ST_VSYNC : ST_IDLE);
            ST_VFRONT: return cont ? ST_VSYNC : ST_IDLE;
            default:   return ST_IDLE;
        endcase
    endfunction

    // Read for pixel x sits two cycles before byte 2x; pixel 0 borrows the previous line.
    function automatic logic rd_pred(input state_e s, input logic [HW-1:0] h, input logic [LW-1:0] l);
        logic nxt_active;
        nxt_active = (s == ST_ACTIVE && l != VA_LAST) ||
                     (s == ST_VBACK && l == VB_LAST) ||
                     (V_BACK == 0 && s == ST_VSYNC && l == VS_LAST);
        return (H_ACTIVE >= 2 && s == ST_ACTIVE && !h[0] && h <= RD_LAST) ||
               (h == H_PRE && nxt_active);
    endfunction

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        if (state_q == ST_IDLE) begin
            if (start_i) begin
                state_d = ST_VSYNC;
                hcnt_d  = '0;
                lcnt_d  = '0;
            end
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            if (lcnt_q == last_line(state_q)) begin
                lcnt_d  = '0;
                state_d = next_state(state_q, continuous_i);
            end else begin
                lcnt_d = lcnt_q + 1'b1;
            end
        end else begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    // Outputs are decoded from next-state values so they line up with the counters.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hcnt_q       <= '0;
            lcnt_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            line_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            lcnt_q       <= lcnt_d;
            busy_q       <= (state_d != ST_IDLE);
            frame_done_q <= (hcnt_d == H_LAST) &&
                            ((state_d == ST_VFRONT && lcnt_d == VF_LAST) ||
                             (V_FRONT == 0 && state_d == ST_ACTIVE && lcnt_d == VA_LAST));
            href_q       <= (state_d == ST_ACTIVE) && (hcnt_d < HREF_END);
            vsync_q      <= (state_d == ST_VSYNC);
            rd_en_q      <= rd_pred(state_d, hcnt_d, lcnt_d);
            line_start_q <= (state_d != ST_IDLE) && (hcnt_d == '0);
        end
    end

    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign href_o       = href_q;
    assign vsync_o      = vsync_q;
    assign rd_en_o      = rd_en_q;
    assign line_start_o = line_start_q;

endmodule

// File: rtl/ov7670_frame_streamer.sv
// OV7670 camera emulator: streams an RGB565 frame memory out as href/vsync/data
// bytes. Owns the pixel address counter, the read-data pipeline and the byte mux.
module ov7670_frame_streamer
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input  logic                     pclk,
    input  logic                     reset,
    ov7670_frame_streamer_if.master  bus
);
    localparam int                STAGES    = 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE*V_ACTIVE - 1);

    logic              rd_en, line_start, busy, frame_done, href, vsync;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [STAGES:0]   vld_pipe_q;
    logic [7:0]        lo_q;
    logic [7:0]        data_q, data_d;

    ov7670_timing_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .pclk         (pclk),
        .reset        (reset),
        .start_i      (bus.start),
        .continuous_i (bus.continuous),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .href_o       (href),
        .vsync_o      (vsync),
        .rd_en_o      (rd_en),
        .line_start_o (line_start)
    );

    // Wrap after the last pixel so the port idles at address 0 between frames.
    always_comb begin
        addr_d = addr_q;
        if (line_start && vsync)
            addr_d = '0;
        else if (rd_en)
            addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
    end

    // vld_pipe_q[0]: read data on mem_rdata now; [1]: low byte of that pixel is next.
    always_comb begin
        data_d = '0;
        if (vld_pipe_q[0])
            data_d = bus.mem_rdata[15:8];
        else if (vld_pipe_q[1])
            data_d = lo_q;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            addr_q     <= '0;
            vld_pipe_q <= '0;
            lo_q       <= '0;
            data_q     <= '0;
        end else begin
            addr_q     <= addr_d;
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], rd_en};
            data_q     <= data_d;
            if (vld_pipe_q[0])
                lo_q <= bus.mem_rdata[7:0];
        end
    end

    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.mem_re     = rd_en;
    assign bus.mem_raddr  = addr_q;
    assign bus.href       = href;
    assign bus.vsync      = vsync;
    assign bus.data       = data_q;

endmodule

// File: tb/tb_ov7670_frame_streamer.sv
// Bench for ov7670_frame_streamer with a small 4x3 frame; outputs are compared cycle
// by cycle with a frame-position model and bytes are reassembled as a capture side would.
module tb_ov7670_frame_streamer;
    localparam int H     = 4;
    localparam int VA    = 3;
    localparam int HB    = 4;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int VF    = 1;
    localparam int L     = 2*H + HB;
    localparam int FRAME = (VS + VB + VA + VF) * L;
    localparam int NPIX  = H * VA;

    logic pclk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total    = 0;

    ov7670_frame_streamer_if bus();

    ov7670_frame_streamer #(
        .H_ACTIVE(H), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    // Frame memory holds 16'hA000+addr; unread cycles return noise.
    always @(posedge pclk)
        bus.mem_rdata <= bus.mem_re ? 16'(16'hA000 + bus.mem_raddr) : 16'($urandom);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs at frame cycle n, from the position of n within the frame.
    task automatic model(input int n, output logic [7:0] d, output logic hr, output logic vs,
                         output logic fd, output logic re, output int ra);
        int ln, h, a, n2, h2, a2;
        logic [15:0] p;
        ln = n / L;  h = n % L;  a = ln - VS - VB;
        vs = (ln < VS);
        hr = (a >= 0 && a < VA && h < 2*H);
        d  = 8'h00;
        if (hr) begin
            p = 16'(16'hA000 + a*H + h/2);
            d = (h % 2 == 1) ? p[7:0] : p[15:8];
        end
        n2 = n + 2;  h2 = n2 % L;  a2 = n2 / L - VS - VB;
        re = 1'b0;  ra = 0;
        if (n2 < FRAME && a2 >= 0 && a2 < VA && h2 < 2*H && h2 % 2 == 0) begin
            re = 1'b1;
            ra = a2*H + h2/2;
        end
        fd = (n == FRAME-1);
    endtask

    task automatic idle_chk(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            chk({tag, " busy"},  bus.busy, 0);
            chk({tag, " vsync"}, bus.vsync, 0);
            chk({tag, " href"},  bus.href, 0);
            chk({tag, " data"},  bus.data, 0);
            chk({tag, " done"},  bus.frame_done, 0);
            chk({tag, " re"},    bus.mem_re, 0);
            chk({tag, " addr"},  bus.mem_raddr, 0);
            @(negedge pclk);
        end
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        @(negedge pclk);
    endtask

    // Checks one frame from its first cycle; random start/continuous are driven
    // throughout, with continuous forced to want_cont in the last cycle.
    task automatic frame_loop(input bit want_cont, input int stop_n);
        logic [7:0] ed, hi;
        logic       eh, ev, efd, ere;
        int         era;
        int         re_cnt = 0, we_cnt = 0, bcnt = 0;
        hi = 8'h00;
        for (int n = 0; n < FRAME; n++) begin
            model(n, ed, eh, ev, efd, ere, era);
            chk($sformatf("busy n=%0d", n),  bus.busy, 1);
            chk($sformatf("vsync n=%0d", n), bus.vsync, ev);
            chk($sformatf("href n=%0d", n),  bus.href, eh);
            chk($sformatf("data n=%0d", n),  bus.data, ed);
            chk($sformatf("done n=%0d", n),  bus.frame_done, efd);
            chk($sformatf("re n=%0d", n),    bus.mem_re, ere);
            if (ere) chk($sformatf("raddr n=%0d", n), bus.mem_raddr, era);
            if (bus.mem_re) begin
                chk($sformatf("raddr seq %0d", re_cnt), bus.mem_raddr, re_cnt);
                re_cnt++;
            end
            if (bus.href) begin
                if (bcnt % 2 == 0) hi = bus.data;
                else begin
                    chk($sformatf("loopback px %0d", we_cnt), {hi, bus.data}, 16'hA000 + we_cnt);
                    we_cnt++;
                end
                bcnt++;
            end
            if (n == stop_n) return;
            bus.start      = 1'($urandom_range(0, 1));
            bus.continuous = (n == FRAME-1) ? want_cont : 1'($urandom_range(0, 1));
            @(negedge pclk);
        end
        chk("re count", re_cnt, NPIX);
        chk("we count", we_cnt, NPIX);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        reset          = 1'b1;
        repeat (3) @(negedge pclk);
        idle_chk(2, "in reset");
        reset = 1'b0;
        idle_chk(2 + $urandom_range(0, 4), "idle");

        // Single frame
        start_frame();
        frame_loop(1'b0, -1);
        bus.start = 1'b0;
        idle_chk(3, "after frame");

        // Two back-to-back continuous frames
        start_frame();
        frame_loop(1'b1, -1);
        frame_loop(1'b0, -1);
        bus.start = 1'b0;
        idle_chk(3, "after cont");

        // Reset at hcnt=5 of active line 1, then a clean frame
        start_frame();
        frame_loop(1'b0, (VS + VB + 1)*L + 5);
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge pclk);
        idle_chk(1, "mid reset");
        reset = 1'b0;
        idle_chk(3, "post reset");
        start_frame();
        frame_loop(1'b0, -1);
        bus.start = 1'b0;
        idle_chk(2, "final");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
